// File: rtl/conv_stream.sv
// Streaming 3x3 convolution (pass/blur/sharpen/edge) over packed multi-channel pixels; CONV_STREAM_SATURATE_EN clamps results, else wrap.
// Latency: output k registered one cycle after input k+IMG_W+1 is accepted, or after the previous output handshake while flushing.
// Backpressure: in_ready drops while a held output is stalled (RUN); out_pixel/out_valid stay stable until out_ready.
module conv_stream #(
    parameter int CH_BITS = 4,
    parameter int NUM_CH  = 3,
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [1:0]                func,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_CH*CH_BITS-1:0] in_pixel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CH*CH_BITS-1:0] out_pixel,
    output logic                      busy,
    output logic                      done
);

    localparam int PW     = NUM_CH * CH_BITS;
    localparam int SW     = CH_BITS + 6;
    localparam int N      = IMG_W * IMG_H;
    localparam int NW     = $clog2(N + 1);
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int SR_LEN = 2 * IMG_W + 2;

    localparam logic [NW-1:0] FILL_LAST = NW'(IMG_W);
    localparam logic [NW-1:0] LAST_IN   = NW'(N - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
`ifdef CONV_STREAM_SATURATE_EN
    localparam logic signed [SW-1:0] CH_MAX = SW'((1 << CH_BITS) - 1);
`endif

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   in_cnt_q, in_cnt_d;
    logic [RW-1:0]   orow_q, orow_d;
    logic [CW-1:0]   ocol_q, ocol_d;
    logic            all_prod_q, all_prod_d;
    logic [1:0]      func_q, func_d;
    logic            out_valid_q, out_valid_d;
    logic [PW-1:0]   out_pixel_q, out_pixel_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [PW-1:0]   sr_q [SR_LEN];
    logic [PW-1:0]   sr_d [SR_LEN];

    logic            slot_free;
    logic            accept;
    logic            shift;
    logic            produce;
    logic [PW-1:0]   shift_in;
    logic [PW-1:0]   win [SR_LEN+1];
    logic [2:0]      row_ok;
    logic [2:0]      col_ok;
    logic [9*CH_BITS-1:0] taps_ch;
    logic [PW-1:0]   conv_pix;

    function automatic logic [CH_BITS-1:0] conv_ch(input logic [9*CH_BITS-1:0] taps,
                                                   input logic [1:0]           f);
        logic signed [SW-1:0] w [9];
        logic signed [SW-1:0] res;
        for (int i = 0; i < 9; i++)
            w[i] = $signed({{(SW-CH_BITS){1'b0}}, taps[i*CH_BITS +: CH_BITS]});
        case (f)
            2'b00:   res = w[4];
            2'b01:   res = (w[0] + (w[1] <<< 1) + w[2] + (w[3] <<< 1) + (w[4] <<< 2)
                           + (w[5] <<< 1) + w[6] + (w[7] <<< 1) + w[8]) >>> 4;
            2'b10:   res = (w[4] <<< 2) + w[4] - w[1] - w[3] - w[5] - w[7];
            default: res = (w[4] <<< 3) - (w[0] + w[1] + w[2] + w[3] + w[5] + w[6] + w[7] + w[8]);
        endcase
`ifdef CONV_STREAM_SATURATE_EN
        if (res[SW-1])
            return '0;
        if (res > CH_MAX)
            return '1;
        return res[CH_BITS-1:0];
`else
        return res[CH_BITS-1:0];
`endif
    endfunction

    assign slot_free = !out_valid_q || out_ready;
    // start gates in_ready so a pixel presented alongside start is never accepted.
    assign in_ready  = !start && ((state_q == S_FILL) || ((state_q == S_RUN) && slot_free));
    assign accept    = in_valid && in_ready;
    assign shift_in  = (state_q == S_FLUSH) ? '0 : in_pixel;

    // win[0] is the pixel entering this cycle; win[(2-r)*IMG_W+(2-c)] is tap w[r][c].
    always_comb begin
        win[0] = shift_in;
        for (int i = 0; i < SR_LEN; i++)
            win[i+1] = sr_q[i];
    end

    assign row_ok = {orow_q != ROW_LAST, 1'b1, orow_q != '0};
    assign col_ok = {ocol_q != COL_LAST, 1'b1, ocol_q != '0};

    always_comb begin
        conv_pix = '0;
        taps_ch  = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    taps_ch[(r*3+c)*CH_BITS +: CH_BITS] = (row_ok[r] && col_ok[c]) ?
                        win[(2-r)*IMG_W + (2-c)][ch*CH_BITS +: CH_BITS] : '0;
            conv_pix[ch*CH_BITS +: CH_BITS] = conv_ch(taps_ch, func_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        orow_d      = orow_q;
        ocol_d      = ocol_q;
        all_prod_d  = all_prod_q;
        func_d      = func_q;
        out_valid_d = out_valid_q;
        out_pixel_d = out_pixel_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        shift       = 1'b0;
        produce     = 1'b0;

        case (state_q)
            S_FILL: begin
                if (accept) begin
                    shift    = 1'b1;
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == FILL_LAST)
                        state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (out_valid_q && out_ready)
                    out_valid_d = 1'b0;
                if (accept) begin
                    shift    = 1'b1;
                    produce  = 1'b1;
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == LAST_IN)
                        state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (all_prod_q) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                // Zeros are shifted in so the window keeps advancing past the last input.
                if (slot_free && !all_prod_q) begin
                    shift   = 1'b1;
                    produce = 1'b1;
                end
            end
            default: ;
        endcase

        if (produce) begin
            out_valid_d = 1'b1;
            out_pixel_d = conv_pix;
            if (ocol_q == COL_LAST) begin
                ocol_d = '0;
                orow_d = orow_q + 1'b1;
                if (orow_q == ROW_LAST)
                    all_prod_d = 1'b1;
            end else begin
                ocol_d = ocol_q + 1'b1;
            end
        end

        if (start) begin
            state_d     = S_FILL;
            in_cnt_d    = '0;
            orow_d      = '0;
            ocol_d      = '0;
            all_prod_d  = 1'b0;
            func_d      = func;
            out_valid_d = 1'b0;
            busy_d      = 1'b1;
            done_d      = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < SR_LEN; i++)
            sr_d[i] = shift ? win[i] : sr_q[i];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_cnt_q    <= '0;
            orow_q      <= '0;
            ocol_q      <= '0;
            all_prod_q  <= 1'b0;
            func_q      <= 2'b00;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            orow_q      <= orow_d;
            ocol_q      <= ocol_d;
            all_prod_q  <= all_prod_d;
            func_q      <= func_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Stale window contents are harmless: border masking hides everything outside the frame.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SR_LEN; i++)
            sr_q[i] <= sr_d[i];
    end

    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_stream.sv
// Directed bench for conv_stream on a 4x3 frame: pass, blur, sharpen, edge, backpressure, abort, reset in flush.
module tb_conv_stream;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int PW = 12;

    logic          clk = 1'b0;
    logic          rst_n, start, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [1:0]    func;
    logic [PW-1:0] in_pixel, out_pixel;

    int            checks = 0;
    int            failures = 0;
    logic [PW-1:0] outs [$];
    logic [PW-1:0] exp_q [$];
    int            ncyc = 0;
    int            last_hs = -1;
    int            done_cyc = -2;
    int            done_cnt = 0;

    int blur_e [12] = '{4, 6, 6, 4, 6, 8, 8, 6, 4, 6, 6, 4};
`ifdef CONV_STREAM_SATURATE_EN
    int shp_e [12] = '{15, 15, 15, 15, 15, 8, 8, 15, 15, 15, 15, 15};
    int edg_e [12] = '{15, 15, 15, 15, 15, 0, 0, 15, 15, 15, 15, 15};
`else
    int shp_e [12] = '{8, 0, 0, 8, 0, 8, 8, 0, 8, 0, 0, 8};
    int edg_e [12] = '{8, 8, 8, 8, 8, 0, 0, 8, 8, 8, 8, 8};
`endif

    always #5 clk = ~clk;

    conv_stream #(.CH_BITS(4), .NUM_CH(3), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func(func),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .busy(busy), .done(done)
    );

    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (rst_n && out_valid && out_ready) begin
            outs.push_back(out_pixel);
            last_hs = ncyc;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = ncyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] pix_of(input int mode, input int i);
        case (mode)
            0:       return PW'(i);
            1:       return 12'h888;
            default: return PW'(i * 'h111);
        endcase
    endfunction

    function automatic logic [PW-1:0] rep(input int v);
        logic [3:0] n;
        n = v[3:0];
        return {n, n, n};
    endfunction

    task automatic do_start(input logic [1:0] f);
        start = 1'b1;
        func  = f;
        @(posedge clk); #1;
        start = 1'b0;
        func  = ~f;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic drive(input int n, input int mode, input int stall_at);
        int   i = 0;
        int   guard = 0;
        bit   stalled = 0;
        logic a;
        while (i < n && guard < 1000) begin
            in_valid = 1'b1;
            in_pixel = pix_of(mode, i);
            if (i == stall_at && !stalled) begin
                stalled   = 1;
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_out_pixel", out_pixel, pix_of(mode, stall_at - W - 2));
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
            a = in_ready;
            @(posedge clk); #1;
            if (a) i++;
            guard++;
        end
        in_valid = 1'b0;
        chk("drive_accepted", i, n);
    endtask

    task automatic wait_done(input int target);
        for (int g = 0; g < 200 && done_cnt < target; g++) begin
            @(negedge clk); #1;
        end
        chk("done_count", done_cnt, target);
        chk("done_latency", done_cyc, last_hs + 1);
        chk("busy_at_done", busy, 0);
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_count"}, outs.size(), 12);
        for (int i = 0; i < 12; i++)
            chk($sformatf("%s[%0d]", tag, i), outs[i], exp_q[i]);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; func = 2'b00;
        in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pixel", out_pixel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Pass on a ramp
        outs.delete(); exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(PW'(i));
        do_start(2'b00);
        drive(12, 0, -1);
        wait_done(1);
        check_outs("pass");

        // Blur on constant 0x888
        outs.delete(); exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(rep(blur_e[i]));
        do_start(2'b01);
        drive(12, 1, -1);
        wait_done(2);
        check_outs("blur");

        // Sharpen on constant 0x888
        outs.delete(); exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(rep(shp_e[i]));
        do_start(2'b10);
        drive(12, 1, -1);
        wait_done(3);
        check_outs("sharpen");

        // Edge on constant 0x888
        outs.delete(); exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(rep(edg_e[i]));
        do_start(2'b11);
        drive(12, 1, -1);
        wait_done(4);
        check_outs("edge");

        // Backpressure: 5-cycle stall mid-RUN
        outs.delete(); exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(pix_of(2, i));
        do_start(2'b00);
        drive(12, 2, 8);
        wait_done(5);
        check_outs("bp");

        // Abort after 7 inputs, start with in_valid high
        do_start(2'b00);
        drive(7, 0, -1);
        start = 1'b1; func = 2'b00; in_valid = 1'b1; in_pixel = 12'hABC;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 0);
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0; func = 2'b11;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 1);
        outs.delete(); exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(pix_of(2, i));
        drive(12, 2, -1);
        wait_done(6);
        check_outs("abort");

        // Reset during FLUSH
        do_start(2'b00);
        drive(12, 0, -1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("flushrst_out_valid", out_valid, 0);
        chk("flushrst_out_pixel", out_pixel, 0);
        chk("flushrst_busy", busy, 0);
        chk("flushrst_done", done, 0);
        chk("flushrst_in_ready", in_ready, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("flushrst_no_done", done_cnt, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
